// File: rtl/column_ram_wr_ctrl.sv
// column_ram_wr_ctrl: write-side sequencer for the 85-lane column RAM.
// Accepts one flattened message word per valid/ready handshake and writes one
// layer of LAYER_ROWS words to consecutive (wrapping) addresses from base_addr.
// Optional feature macro: COL_RAM_WR_NZ_FLAG_EN adds the sticky layer_nz output.
module column_ram_wr_ctrl #(
  parameter int QUAN_SIZE         = 4,
  parameter int CHECK_PARALLELISM = 85,
  parameter int LAYER_ROWS        = 9,
  parameter int DEPTH             = 1024,
  parameter int ADDR              = $clog2(DEPTH)
) (
  input  logic                                   sys_clk,
  input  logic                                   rst,
  input  logic                                   layer_start,
  input  logic [ADDR-1:0]                        base_addr,
  input  logic [CHECK_PARALLELISM*QUAN_SIZE-1:0] msg_in,
  input  logic                                   msg_valid,
  output logic                                   msg_ready,
  output logic [CHECK_PARALLELISM*QUAN_SIZE-1:0] din_bus,
  output logic [ADDR-1:0]                        sync_addr,
  output logic                                   we,
  output logic                                   busy,
`ifdef COL_RAM_WR_NZ_FLAG_EN
  output logic                                   layer_nz,
`endif
  output logic                                   layer_done
);

  localparam int WORD_W = CHECK_PARALLELISM * QUAN_SIZE;
  localparam int ROW_W  = (LAYER_ROWS > 1) ? $clog2(LAYER_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LAYER_ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR-1:0]     addr_cnt_q, addr_cnt_d;
  logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
  logic [WORD_W-1:0]   din_q, din_d;
  logic [ADDR-1:0]     sync_addr_q, sync_addr_d;
  logic                we_q, we_d;
  logic                msg_ready_q, msg_ready_d;
  logic                accept;

`ifdef COL_RAM_WR_NZ_FLAG_EN
  logic                         nz_q, nz_d;
  logic [CHECK_PARALLELISM-1:0] lane_nz;
  logic                         word_nz;

  // Per-lane nonzero detect, OR-reduced into one flag for the whole word.
  for (genvar gi = 0; gi < CHECK_PARALLELISM; gi++) begin : g_lane_nz
    assign lane_nz[gi] = |msg_in[gi*QUAN_SIZE +: QUAN_SIZE];
  end
  assign word_nz  = |lane_nz;
  assign layer_nz = nz_q;
`endif

  // msg_ready_q is only high in WRITE, so this is a registered handshake.
  assign accept = msg_valid & msg_ready_q;

  // Next-state and datapath: capture on arm, stage each accepted word for one cycle.
  always_comb begin
    state_d     = state_q;
    addr_cnt_d  = addr_cnt_q;
    row_cnt_d   = row_cnt_q;
    din_d       = din_q;
    sync_addr_d = sync_addr_q;
    we_d        = 1'b0;
`ifdef COL_RAM_WR_NZ_FLAG_EN
    nz_d        = nz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (layer_start) begin
          addr_cnt_d = base_addr;
          row_cnt_d  = '0;
          state_d    = ST_WRITE;
`ifdef COL_RAM_WR_NZ_FLAG_EN
          nz_d       = 1'b0;
`endif
        end
      end
      ST_WRITE: begin
        if (accept) begin
          we_d        = 1'b1;
          din_d       = msg_in;
          sync_addr_d = addr_cnt_q;
          addr_cnt_d  = addr_cnt_q + ADDR'(1);
          row_cnt_d   = row_cnt_q + ROW_W'(1);
`ifdef COL_RAM_WR_NZ_FLAG_EN
          nz_d        = nz_q | word_nz;
`endif
          if (row_cnt_q == LAST_ROW) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // The last word is being written this cycle; a new arm waits for IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    msg_ready_d = (state_d == ST_WRITE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_cnt_q  <= '0;
      row_cnt_q   <= '0;
      din_q       <= '0;
      sync_addr_q <= '0;
      we_q        <= 1'b0;
      msg_ready_q <= 1'b0;
`ifdef COL_RAM_WR_NZ_FLAG_EN
      nz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      row_cnt_q   <= row_cnt_d;
      din_q       <= din_d;
      sync_addr_q <= sync_addr_d;
      we_q        <= we_d;
      msg_ready_q <= msg_ready_d;
`ifdef COL_RAM_WR_NZ_FLAG_EN
      nz_q        <= nz_d;
`endif
    end
  end

  assign msg_ready  = msg_ready_q;
  assign din_bus    = din_q;
  assign sync_addr  = sync_addr_q;
  assign we         = we_q;
  assign busy       = (state_q != ST_IDLE);
  assign layer_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_column_ram_wr_ctrl.sv
// Testbench for column_ram_wr_ctrl: table of layer scenarios plus hand-written
// reset/abort sequences; expected RAM writes go through a scoreboard queue.
module tb_column_ram_wr_ctrl;

  localparam int QS   = 4;
  localparam int CP   = 85;
  localparam int ROWS = 9;
  localparam int ADDR = 10;
  localparam int DW   = CP * QS;

  logic            sys_clk = 1'b0;
  logic            rst = 1'b1;
  logic            layer_start = 1'b0;
  logic [ADDR-1:0] base_addr = '0;
  logic [DW-1:0]   msg_in = '0;
  logic            msg_valid = 1'b0;
  logic            msg_ready;
  logic [DW-1:0]   din_bus;
  logic [ADDR-1:0] sync_addr;
  logic            we;
  logic            busy;
  logic            layer_done;
`ifdef COL_RAM_WR_NZ_FLAG_EN
  logic            layer_nz;
`endif

  column_ram_wr_ctrl #(
    .QUAN_SIZE(QS), .CHECK_PARALLELISM(CP), .LAYER_ROWS(ROWS), .DEPTH(1024)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .layer_start(layer_start),
    .base_addr  (base_addr),
    .msg_in     (msg_in),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .din_bus    (din_bus),
    .sync_addr  (sync_addr),
    .we         (we),
    .busy       (busy),
`ifdef COL_RAM_WR_NZ_FLAG_EN
    .layer_nz   (layer_nz),
`endif
    .layer_done (layer_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [ADDR-1:0] addr;
    logic [DW-1:0]   data;
    logic            last;
  } wr_t;

  typedef struct {
    logic [ADDR-1:0] base;
    int              period;   // msg_valid high when cycle % period == 0
    int              mode;     // 0: lane i = i%16, 1: random, 2: zero, 3: one nonzero lane in word 5
    logic [ADDR-1:0] exp_last;
    bit              poke;     // drive layer_start during WRITE and DONE
    bit              exp_nz;
  } vec_t;

  wr_t             exp_q[$];
  vec_t            tbl[7];
  int              total = 0;
  int              bad = 0;
  logic [ADDR-1:0] m_addr;
  int              m_rows;
  bit              m_nz;
  int              n_writes;
  bit              saw_done;
  logic [ADDR-1:0] last_addr;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] make_word(input int mode, input int k);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < CP; i++) begin
      case (mode)
        0: w[i*QS +: QS] = 4'(i % 16);
        1: w[i*QS +: QS] = 4'($urandom_range(0, 15));
        3: if (k == 5 && i == 7) w[i*QS +: QS] = 4'h3;
        default: w[i*QS +: QS] = 4'h0;
      endcase
    end
    return w;
  endfunction

  // One clock: record any accept in the scoreboard, then check the RAM port after the edge.
  task automatic step();
    wr_t e;
    if (msg_valid === 1'b1 && msg_ready === 1'b1 && rst === 1'b0) begin
      e.addr = m_addr;
      e.data = msg_in;
      e.last = (m_rows == ROWS - 1);
      exp_q.push_back(e);
      m_addr = m_addr + ADDR'(1);
      m_rows++;
      if (|msg_in) m_nz = 1'b1;
    end
    @(posedge sys_clk);
    #1;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("we_without_accept", DW'(we), DW'(0));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", DW'(sync_addr), DW'(e.addr));
        check("wr_data", din_bus, e.data);
        check("wr_layer_done", DW'(layer_done), DW'(e.last));
        $display("write addr=%03h done=%0b", sync_addr, layer_done);
        n_writes++;
        last_addr = sync_addr;
        if (layer_done === 1'b1) saw_done = 1'b1;
      end
    end else begin
      if (exp_q.size() != 0) begin
        check("we_after_accept", DW'(we), DW'(1));
        exp_q.delete();
      end
      check("done_without_we", DW'(layer_done), DW'(0));
    end
  endtask

  task automatic run_layer(input vec_t t);
    base_addr   = t.base;
    layer_start = 1'b1;
    msg_valid   = 1'b0;
    m_addr      = t.base;
    m_rows      = 0;
    m_nz        = 1'b0;
    n_writes    = 0;
    saw_done    = 1'b0;
    check("busy_idle", DW'(busy), DW'(0));
    step();
    layer_start = 1'b0;
    check("busy_after_arm", DW'(busy), DW'(1));
    for (int c = 0; c < 200 && !saw_done; c++) begin
      check("msg_ready", DW'(msg_ready), DW'(m_rows < ROWS));
      msg_valid = ((c % t.period) == 0);
      msg_in    = make_word(t.mode, m_rows);
      if (t.poke && c >= 2 && c <= 4) begin
        layer_start = 1'b1;
        base_addr   = 10'h200;
      end else begin
        layer_start = 1'b0;
      end
      step();
    end
    layer_start = 1'b0;
    check("layer_done_seen", DW'(saw_done), DW'(1));
    check("write_count", DW'(n_writes), DW'(ROWS));
    check("last_addr", DW'(last_addr), DW'(t.exp_last));
`ifdef COL_RAM_WR_NZ_FLAG_EN
    check("layer_nz", DW'(layer_nz), DW'(t.exp_nz));
`endif
    msg_valid   = 1'b0;
    layer_start = t.poke;   // arrives in the DONE cycle and must be ignored
    base_addr   = 10'h300;
    step();
    layer_start = 1'b0;
    check("busy_after_done", DW'(busy), DW'(0));
    check("ready_after_done", DW'(msg_ready), DW'(0));
    step();
    check("busy_stays_idle", DW'(busy), DW'(0));
    $display("layer base=%03h period=%0d mode=%0d writes=%0d last=%03h", t.base, t.period, t.mode, n_writes, last_addr);
  endtask

  // Arm, accept four words, then reset: the layer is abandoned with no further writes.
  task automatic abort_seq();
    base_addr   = 10'h050;
    layer_start = 1'b1;
    m_addr      = 10'h050;
    m_rows      = 0;
    n_writes    = 0;
    saw_done    = 1'b0;
    step();
    layer_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      msg_valid = 1'b1;
      msg_in    = make_word(1, c);
      step();
    end
    check("abort_writes_before_rst", DW'(n_writes), DW'(4));
    rst       = 1'b1;
    msg_valid = 1'b1;
    step();
    check("abort_busy", DW'(busy), DW'(0));
    check("abort_ready", DW'(msg_ready), DW'(0));
    check("abort_addr", DW'(sync_addr), DW'(0));
    rst = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("abort_no_done", DW'(saw_done), DW'(0));
    check("abort_no_more_writes", DW'(n_writes), DW'(4));
    msg_valid = 1'b0;
    $display("abort writes=%0d done=%0b", n_writes, saw_done);
  endtask

  initial begin
    tbl[0] = '{10'h010, 1, 0, 10'h018, 1'b0, 1'b1};
    tbl[1] = '{10'h020, 3, 1, 10'h028, 1'b0, 1'b1};
    tbl[2] = '{10'h3FC, 1, 1, 10'h004, 1'b0, 1'b1};
    tbl[3] = '{10'h3FF, 2, 1, 10'h007, 1'b0, 1'b1};
    tbl[4] = '{10'h100, 1, 1, 10'h108, 1'b1, 1'b1};
    tbl[5] = '{10'h000, 1, 2, 10'h008, 1'b0, 1'b0};
    tbl[6] = '{10'h040, 1, 3, 10'h048, 1'b0, 1'b1};

    m_addr = '0;
    m_rows = 0;
    m_nz   = 1'b0;

    // Reset held with valid and layer_start active must leave everything idle.
    rst         = 1'b1;
    msg_valid   = 1'b1;
    layer_start = 1'b1;
    base_addr   = 10'h123;
    msg_in      = make_word(1, 0);
    step();
    step();
    check("rst_ready", DW'(msg_ready), DW'(0));
    check("rst_we", DW'(we), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(layer_done), DW'(0));
    check("rst_addr", DW'(sync_addr), DW'(0));
    check("rst_din", din_bus, DW'(0));
`ifdef COL_RAM_WR_NZ_FLAG_EN
    check("rst_nz", DW'(layer_nz), DW'(0));
`endif
    $display("reset ready=%0b we=%0b busy=%0b done=%0b", msg_ready, we, busy, layer_done);
    rst         = 1'b0;
    msg_valid   = 1'b0;
    layer_start = 1'b0;
    step();
    check("post_rst_busy", DW'(busy), DW'(0));

    for (int i = 0; i < 7; i++) begin
      if (i == 4) abort_seq();
      run_layer(tbl[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
